spi_rx: RTL and testbench

- Serial target for the TM1638-style 3-wire bus: STB active-low, CLK idle-high, DIO bidirectional, LSB-first.
- Sits on the far end of the existing spi master. Used as an on-chip display-controller model for loopback and as the key-scan responder.
- Decodes received bytes into a valid-strobed byte stream.
- On a read command (0x42), drives 32 bits of key data back onto DIO.

---
 rtl/spi_rx.sv | 179 +++++++++++++++++
 tb/tb_spi_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// spi_rx: serial target for a TM1638-style 3-wire bus (STB active-low,
// CLK idle-high, bidirectional DIO, LSB first). Received bytes come out as
// a valid-strobed stream. A READ_CMD command byte makes the block return
// 32 bits of key data on DIO.
// Optional diagnostics: define SPI_RX_DIAG_EN to expose the FSM state and
// the bit counter on o_Diag_State / o_Diag_Bits; otherwise both read 0.
//
// Handshake: o_Data_Valid is a single-cycle strobe with no back-pressure;
// o_Data/o_First are valid in that cycle and hold until the next strobe.
module spi_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  READ_CMD    = 8'h42
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_SPI_Stb,
    input  logic        i_SPI_Clk,
    inout  wire         io_SPI_Dio,
    input  logic [31:0] i_Keys,
    output logic        o_Data_Valid,
    output logic [7:0]  o_Data,
    output logic        o_First,
    output logic        o_Frame_Err,
    output logic [1:0]  o_Diag_State,
    output logic [2:0]  o_Diag_Bits
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RX   = 2'd2,
        ST_READ = 2'd3
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
    logic       stb_s, clk_s, dio_s;
    logic       stb_q, clk_q;
    logic       stb_rise, stb_fall, clk_rise, clk_fall;

    logic [2:0]  bitcnt;
    logic [7:0]  rx_byte;
    logic [7:0]  byte_full;
    logic        first_flag;
    logic        is_cmd;
    logic [31:0] key_shift;
    logic [5:0]  rd_cnt;
    logic        dio_oe;
    logic        dio_out;

    // Input synchronizers; STB syncs to 0 so a mid-frame reset never sees a fake idle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            stb_sync <= '0;
            clk_sync <= '0;
            dio_sync <= '0;
            stb_q    <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], io_SPI_Dio};
            stb_q    <= stb_s;
            clk_q    <= clk_s;
        end
    end

    assign stb_s    = stb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dio_s    = dio_sync[SYNC_STAGES-1];
    assign stb_rise = stb_s & ~stb_q;
    assign stb_fall = ~stb_s & stb_q;
    assign clk_rise = clk_s & ~clk_q;
    assign clk_fall = ~clk_s & clk_q;

    // Byte as it will look once the current sample lands in bit 7.
    assign byte_full = {dio_s, rx_byte[6:0]};
    assign is_cmd    = first_flag && (byte_full == READ_CMD);

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) state <= ST_WAIT;
        else       state <= state_n;
    end

    // Next-state logic; STB rise always wins over a coincident CLK rise.
    always_comb begin
        state_n = state;
        case (state)
            ST_WAIT: if (stb_s) state_n = ST_IDLE;
            ST_IDLE: if (stb_fall) state_n = ST_RX;
            ST_RX: begin
                if (stb_rise)
                    state_n = ST_IDLE;
                else if (clk_rise && bitcnt == 3'd7 && is_cmd)
                    state_n = ST_READ;
            end
            ST_READ: if (stb_rise) state_n = ST_IDLE;
            default: state_n = ST_WAIT;
        endcase
    end

    // Receive shifter, output strobes and key read-back shifter.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bitcnt       <= 3'd0;
            rx_byte      <= 8'd0;
            first_flag   <= 1'b0;
            o_Data       <= 8'd0;
            o_First      <= 1'b0;
            o_Data_Valid <= 1'b0;
            o_Frame_Err  <= 1'b0;
            key_shift    <= 32'd0;
            rd_cnt       <= 6'd0;
            dio_oe       <= 1'b0;
            dio_out      <= 1'b0;
        end else begin
            o_Data_Valid <= 1'b0;
            o_Frame_Err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dio_oe <= 1'b0;
                    if (stb_fall) begin
                        bitcnt     <= 3'd0;
                        first_flag <= 1'b1;
                    end
                end
                ST_RX: begin
                    if (stb_rise) begin
                        if (bitcnt != 3'd0) o_Frame_Err <= 1'b1;
                        bitcnt <= 3'd0;
                    end else if (clk_rise) begin
                        rx_byte[bitcnt] <= dio_s;
                        bitcnt          <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            o_Data       <= byte_full;
                            o_First      <= first_flag;
                            o_Data_Valid <= 1'b1;
                            first_flag   <= 1'b0;
                            if (is_cmd) begin
                                key_shift <= i_Keys;
                                rd_cnt    <= 6'd0;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (stb_rise) begin
                        dio_oe <= 1'b0;
                        rd_cnt <= 6'd0;
                    end else if (clk_fall) begin
                        if (rd_cnt != 6'd32) begin
                            dio_oe    <= 1'b1;
                            dio_out   <= key_shift[0];
                            key_shift <= {1'b0, key_shift[31:1]};
                            rd_cnt    <= rd_cnt + 6'd1;
                        end else begin
                            dio_oe <= 1'b0;
                        end
                    end
                end
                default: dio_oe <= 1'b0;
            endcase
        end
    end

    // Release DIO combinationally on the detected STB rise so the bus is free that cycle.
    assign io_SPI_Dio = (dio_oe && !stb_rise) ? dio_out : 1'bz;

`ifdef SPI_RX_DIAG_EN
    assign o_Diag_State = state;
    assign o_Diag_Bits  = (state == ST_READ) ? rd_cnt[2:0] : bitcnt;
`else
    assign o_Diag_State = 2'd0;
    assign o_Diag_Bits  = 3'd0;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: a bus master drives frames, a byte-level model keeps the
// expected (first, data) queue and frame-error count, and a monitor compares
// the DUT against it on every cycle.
module tb_spi_rx;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        sclk;
    logic        m_oe;
    logic        m_dio;
    logic [31:0] keys;
    wire         dio;

    logic        o_data_valid;
    logic [7:0]  o_data;
    logic        o_first;
    logic        o_frame_err;
    logic [1:0]  o_diag_state;
    logic [2:0]  o_diag_bits;

    assign dio = m_oe ? m_dio : 1'bz;
    pullup (dio);

    spi_rx dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_SPI_Stb    (stb),
        .i_SPI_Clk    (sclk),
        .io_SPI_Dio   (dio),
        .i_Keys       (keys),
        .o_Data_Valid (o_data_valid),
        .o_Data       (o_data),
        .o_First      (o_first),
        .o_Frame_Err  (o_frame_err),
        .o_Diag_State (o_diag_state),
        .o_Diag_Bits  (o_diag_bits)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_cmp;
    int         n_bad;
    int         err_seen;
    int         exp_err;
    int         hp;
    logic [8:0] exp_q[$];
    logic [7:0] tx_q[$];
    int         part_bits;
`ifdef SPI_RX_DIAG_EN
    logic [1:0] walk_q[$];
    logic [1:0] last_st;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid strobe must match the head of the model queue.
    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (o_data_valid) begin
                check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data", 32'(o_data), 32'(e[7:0]));
                    check("first", 32'(o_first), 32'(e[8]));
                end
            end
            if (o_frame_err) err_seen++;
`ifdef SPI_RX_DIAG_EN
            if (o_diag_state != last_st) begin
                walk_q.push_back(o_diag_state);
                last_st = o_diag_state;
            end
`else
            check("diag_zero", 32'({o_diag_state, o_diag_bits}), 32'd0);
`endif
        end
    endtask

    // Driver: one byte (or its first nbits) LSB first, data set on CLK fall.
    task automatic m_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk  = 1'b0;
            m_oe  = 1'b1;
            m_dio = b[i];
            wait_cyc(hp);
            sclk = 1'b1;
            wait_cyc(hp);
        end
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frame_err"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_dio_released"}, 32'(dio), 32'd1);
    endtask

    // Driver: whole frame from tx_q, optionally followed by a partial byte.
    task automatic send_frame(input string tag);
        stb = 1'b0;
        wait_cyc(hp);
        for (int i = 0; i < tx_q.size(); i++) begin
            exp_q.push_back({(i == 0), tx_q[i]});
            m_byte(tx_q[i], 8);
        end
        if (part_bits > 0) begin
            exp_err++;
            m_byte(8'($urandom_range(0, 255)), part_bits);
        end
        m_oe = 1'b0;
        wait_cyc(hp);
        stb = 1'b1;
        wait_cyc(4 * hp);
        frame_checks(tag);
    endtask

    // Driver: read command plus 32 read clocks and one extra clock.
    task automatic read_frame(input string tag, input logic [31:0] k, output logic [31:0] word);
        keys = k;
        stb  = 1'b0;
        wait_cyc(hp);
        exp_q.push_back({1'b1, 8'h42});
        m_byte(8'h42, 8);
        m_oe = 1'b0;
        word = 32'd0;
        for (int i = 0; i < 32; i++) begin
            sclk = 1'b0;
            wait_cyc(hp);
            word[i] = dio;
            sclk = 1'b1;
            wait_cyc(hp);
        end
        check({tag, "_read_word"}, word, k);
        sclk = 1'b0;
        wait_cyc(hp);
        check({tag, "_hiz_after_33"}, 32'(dio), 32'd1);
        sclk = 1'b1;
        wait_cyc(hp);
        stb = 1'b1;
        wait_cyc(4 * hp);
        frame_checks(tag);
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] k;
        bit          forced_low;
        int          kind;
        int          nb;
        n_cmp = 0; n_bad = 0; err_seen = 0; exp_err = 0; hp = 4;
        part_bits = 0; forced_low = 0;
        rst = 1'b1; stb = 1'b1; sclk = 1'b1; m_oe = 1'b0; m_dio = 1'b0; keys = 32'd0;
`ifdef SPI_RX_DIAG_EN
        last_st = 2'd0;
`endif
        fork
            monitor();
        join_none

        // Reset state.
        wait_cyc(3);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_first", 32'(o_first), 32'd0);
        check("rst_valid", 32'(o_data_valid), 32'd0);
        check("rst_err", 32'(o_frame_err), 32'd0);
        rst = 1'b0;
        wait_cyc(10);
        check("rst_dio_hiz", 32'(dio), 32'd1);

        // Single byte 0x40.
        tx_q = '{8'h40};
        send_frame("f40");
        check("f40_literal", 32'(o_data), 32'h40);
        check("f40_first_literal", 32'(o_first), 32'd1);

        // Four-byte frame.
        tx_q = '{8'hC0, 8'h01, 8'h02, 8'h03};
        send_frame("f4");
        check("f4_last_literal", 32'(o_data), 32'h03);
        check("f4_first_last", 32'(o_first), 32'd0);

        // Key read.
`ifdef SPI_RX_DIAG_EN
        rst = 1'b1;
        wait_cyc(2);
        walk_q.delete();
        last_st = 2'd3;
        rst = 1'b0;
        wait_cyc(10);
`endif
        read_frame("rd", 32'hA53C_0F81, word);
        check("rd_b0", 32'(word[7:0]), 32'h81);
        check("rd_b1", 32'(word[15:8]), 32'h0F);
        check("rd_b2", 32'(word[23:16]), 32'h3C);
        check("rd_b3", 32'(word[31:24]), 32'hA5);
`ifdef SPI_RX_DIAG_EN
        check("walk_len", 32'(walk_q.size()), 32'd5);
        if (walk_q.size() == 5) begin
            check("walk0", 32'(walk_q[0]), 32'd0);
            check("walk1", 32'(walk_q[1]), 32'd1);
            check("walk2", 32'(walk_q[2]), 32'd2);
            check("walk3", 32'(walk_q[3]), 32'd3);
            check("walk4", 32'(walk_q[4]), 32'd1);
        end
`endif

        // Partial byte of 5 bits, then a clean frame.
        tx_q.delete();
        part_bits = 5;
        send_frame("part");
        check("part_err_literal", 32'(err_seen), 32'd1);
        part_bits = 0;
        tx_q = '{8'h44};
        send_frame("f44");

        // Reset after 3 bits of a byte with STB low.
        stb = 1'b0;
        wait_cyc(hp);
        m_byte(8'h05, 3);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data", 32'(o_data), 32'd0);
        check("midrst_first", 32'(o_first), 32'd0);
        check("midrst_valid", 32'(o_data_valid), 32'd0);
        check("midrst_err", 32'(o_frame_err), 32'd0);
        wait_cyc(1);
        m_byte(8'h00, 5);
        m_oe = 1'b0;
        wait_cyc(hp);
        stb = 1'b1;
        wait_cyc(4 * hp);
        frame_checks("midrst");
        tx_q = '{8'h8F};
        send_frame("f8f");

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            hp   = $urandom_range(4, 6);
            kind = $urandom_range(0, 3);
            if (kind == 3 || (f == 20 && !forced_low)) begin
                k = $urandom;
                if (!forced_low) begin
                    k[31] = 1'b0;
                    forced_low = 1;
                end
                read_frame("rnd_rd", k, word);
            end else begin
                tx_q.delete();
                nb = $urandom_range(1, 4);
                for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                if (tx_q[0] == 8'h42) tx_q[0] = 8'h43;
                part_bits = (kind == 2) ? $urandom_range(1, 7) : 0;
                send_frame("rnd");
            end
        end
        part_bits = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
